uart_frame_transmitter: RTL and testbench
=========================================

UART_FRAME_TRANSMITTER -- requirements
Module: uart_frame_transmitter

Interface
REQ-001 SHALL have parameter WORD_BITS, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter SAMPLE_TICKS, default 16, baud ticks per transmitted bit, legal range 8..32.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port reset_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port baud_i  input  1  one-clk-wide oversample tick from the external baud_generator.
REQ-006 SHALL have port tx_valid_i  input  1  frame request.
REQ-007 SHALL have port data_i  input  WORD_BITS  frame payload, LSB sent first.
REQ-008 SHALL have port parity_mode_i  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
REQ-009 SHALL have port stop2_i  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port tx_ready_o  output  1  high when a request can be accepted.
REQ-011 SHALL have port busy_o  output  1  high while a frame is in progress.
REQ-012 SHALL have port tx_done_o  output  1  one-clk pulse at frame end.
REQ-013 SHALL have port tx_o  output  1  serial line, idle high.

Function
REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL drive tx_ready_o = (state == IDLE); SHALL drive busy_o = !tx_ready_o.
REQ-016 SHALL accept a request on the clk edge where tx_valid_i && tx_ready_o, latching data_i, parity_mode_i and stop2_i, and entering START.
REQ-017 SHALL drive tx_o low from the clk edge after acceptance (1-clk latency).
REQ-018 SHALL hold each bit for exactly SAMPLE_TICKS baud_i pulses counted from state entry; the tick counter SHALL be $clog2(SAMPLE_TICKS) bits, clear on each bit boundary.
REQ-019 SHALL shift WORD_BITS data bits LSB first in DATA, using a $clog2(WORD_BITS)-bit index.
REQ-020 SHALL enter PARITY after DATA only for modes 01/10; even sends XOR of payload, odd sends its inverse.
REQ-021 SHALL hold tx_o high in STOP for SAMPLE_TICKS ticks (1 stop) or 2*SAMPLE_TICKS ticks (stop2 latched).
REQ-022 SHALL return to IDLE and pulse tx_done_o for one clk on the final tick of STOP.
REQ-023 SHALL ignore tx_valid_i while busy; requests are not queued.
REQ-024 SHALL permit back-to-back frames: a request held high during tx_done_o is accepted on the next clk, with no extra idle bit inserted.
REQ-025 SHALL ignore changes to data_i, parity_mode_i, stop2_i mid-frame.
REQ-026 SHALL not advance bit timing on clocks without baud_i; baud_i in IDLE has no effect.

Reset
REQ-027 SHALL, while reset_ni is low, force state IDLE, tx_o=1, tx_ready_o=1, busy_o=0, tx_done_o=0, counters and shift register cleared, asynchronously.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately with tx_o high and no tx_done_o pulse.

Structure
REQ-029 SHALL take parity-mode encodings and the FSM state enum from shared package uart_pkg.
REQ-030 SHALL contain no sub-modules; baud_generator SHALL be instantiated beside it by the integrator/bench.

Verification (100 MHz clk, baud_generator M=651, SAMPLE_TICKS=16, bit ~104.17 us)
REQ-031 SHALL check: data 0x55, parity 00, stop2 0 -> tx_o sequence 0,1,0,1,0,1,0,1,0,1 then one tx_done_o pulse after ~10 bit times.
REQ-032 SHALL check: data 0xCC, parity 01 -> bits 0,00110011,0(even),1; with parity 10 -> parity bit 1.
REQ-033 SHALL check: WORD_BITS=5, data 5'h13, stop2 1 -> 0,11001,1,1; tx_done_o at ~8 bit times.
REQ-034 SHALL check: tx_valid_i held high for two frames (0xA5,0x3C) -> second start bit begins 1 clk after first tx_done_o; tx_valid_i pulsed mid-frame is ignored.
REQ-035 SHALL check: reset_ni low during bit 3 -> tx_o=1 same timestep, tx_ready_o=1, no tx_done_o; next frame 0x0F transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter: FSM state encoding and
// parity-mode codes, plus small helpers that decode the parity mode.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef logic [1:0] parity_mode_t;

    localparam parity_mode_t PAR_NONE = 2'b00;
    localparam parity_mode_t PAR_EVEN = 2'b01;
    localparam parity_mode_t PAR_ODD  = 2'b10;
    localparam parity_mode_t PAR_RSVD = 2'b11;

    // The reserved code behaves exactly like "no parity".
    function automatic logic parity_enabled(input parity_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    function automatic logic parity_invert(input parity_mode_t mode);
        return (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_frame_transmitter.sv
// Serialises one start bit, WORD_BITS data bits (LSB first), optional parity
// and one or two stop bits, timing each bit with SAMPLE_TICKS external baud ticks.
module uart_frame_transmitter
    import uart_pkg::*;
#(
    parameter int WORD_BITS    = 8,
    parameter int SAMPLE_TICKS = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 baud_i,
    input  logic                 tx_valid_i,
    input  logic [WORD_BITS-1:0] data_i,
    input  logic [1:0]           parity_mode_i,
    input  logic                 stop2_i,
    output logic                 tx_ready_o,
    output logic                 busy_o,
    output logic                 tx_done_o,
    output logic                 tx_o
);

    localparam int TICK_W = $clog2(SAMPLE_TICKS);
    localparam int IDX_W  = $clog2(WORD_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORD_BITS - 1);

    tx_state_t             r_state;
    logic [TICK_W-1:0]     r_tick;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_BITS-1:0]  r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_stop_cnt;
    logic                  r_tx;
    logic                  r_done;

    logic                  w_bit_end;

    assign w_bit_end = baud_i && (r_tick == TICK_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= IDLE;
            r_tick     <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Tick counter only runs inside a frame and restarts at every bit boundary.
            if ((r_state != IDLE) && baud_i) begin
                r_tick <= w_bit_end ? '0 : r_tick + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (tx_valid_i) begin
                        r_shift    <= data_i;
                        r_par_en   <= parity_enabled(parity_mode_i);
                        r_par_bit  <= (^data_i) ^ parity_invert(parity_mode_i);
                        r_stop2    <= stop2_i;
                        r_idx      <= '0;
                        r_stop_cnt <= 1'b0;
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (r_idx == IDX_LAST) begin
                            if (r_par_en) begin
                                r_tx    <= r_par_bit;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end

                PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    // A second stop bit simply re-runs the bit timer once more.
                    if (w_bit_end) begin
                        if (r_stop2 && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready_o = (r_state == IDLE);
    assign busy_o     = ~tx_ready_o;
    assign tx_done_o  = r_done;
    assign tx_o       = r_tx;

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Self-checking bench: two transmitter instances (8-bit/16-tick and 5-bit/8-tick)
// driven by a random baud tick, compared against an expected per-tick line model.
module tb_uart_frame_transmitter;

    localparam int ST8       = 16;
    localparam int ST5       = 8;
    localparam int CYC_LIMIT = 5000;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud    = 1'b0;

    logic       valid8 = 1'b0;
    logic [7:0] data8  = '0;
    logic [1:0] par8   = '0;
    logic       stop8  = 1'b0;
    logic       ready8, busy8, done8, tx8;

    logic       valid5 = 1'b0;
    logic [4:0] data5  = '0;
    logic [1:0] par5   = '0;
    logic       stop5  = 1'b0;
    logic       ready5, busy5, done5, tx5;

    logic       cur_sel = 1'b0;
    logic       cur_tx, cur_ready, cur_busy, cur_done;

    int checks = 0;
    int errors = 0;

    assign cur_tx    = cur_sel ? tx5    : tx8;
    assign cur_ready = cur_sel ? ready5 : ready8;
    assign cur_busy  = cur_sel ? busy5  : busy8;
    assign cur_done  = cur_sel ? done5  : done8;

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            baud = ($urandom_range(0, 2) == 0);
        end
    end

    uart_frame_transmitter #(.WORD_BITS(8), .SAMPLE_TICKS(ST8)) dut8 (
        .clk_i(clk), .reset_ni(reset_n), .baud_i(baud),
        .tx_valid_i(valid8), .data_i(data8), .parity_mode_i(par8), .stop2_i(stop8),
        .tx_ready_o(ready8), .busy_o(busy8), .tx_done_o(done8), .tx_o(tx8)
    );

    uart_frame_transmitter #(.WORD_BITS(5), .SAMPLE_TICKS(ST5)) dut5 (
        .clk_i(clk), .reset_ni(reset_n), .baud_i(baud),
        .tx_valid_i(valid5), .data_i(data5), .parity_mode_i(par5), .stop2_i(stop5),
        .tx_ready_o(ready5), .busy_o(busy5), .tx_done_o(done5), .tx_o(tx5)
    );

    task automatic set_valid(input bit sel5, input logic v);
        if (sel5) valid5 = v;
        else      valid8 = v;
    endtask

    task automatic idle_cycles(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (cur_tx !== 1'b1 || cur_ready !== 1'b1 || cur_busy !== 1'b0 || cur_done !== 1'b0) begin
                errors++;
                $display("FAIL %s idle: tx=%b ready=%b busy=%b done=%b, required tx=1 ready=1 busy=0 done=0",
                         name, cur_tx, cur_ready, cur_busy, cur_done);
            end
        end
    endtask

    // Called at a negedge; the request is accepted on the following posedge.
    task automatic run_frame(input bit sel5, input logic [8:0] d, input logic [1:0] m,
                             input logic s2, input bit hold_valid, input bit noise,
                             input string name);
        bit   exp_q[$];
        int   wb, st, total, ticks;
        bit   p, finished;
        wb = sel5 ? 5 : 8;
        st = sel5 ? ST5 : ST8;
        cur_sel = sel5;

        exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < wb; i++) begin
            exp_q.push_back(d[i]);
            p ^= d[i];
        end
        if (m == 2'b01) exp_q.push_back(p);
        if (m == 2'b10) exp_q.push_back(~p);
        exp_q.push_back(1'b1);
        if (s2) exp_q.push_back(1'b1);
        total = exp_q.size() * st;

        if (sel5) begin data5 = d[4:0]; par5 = m; stop5 = s2; end
        else      begin data8 = d[7:0]; par8 = m; stop8 = s2; end
        set_valid(sel5, 1'b1);

        @(posedge clk);
        #1;
        checks++;
        if (cur_tx !== 1'b0 || cur_ready !== 1'b0 || cur_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start: tx=%b ready=%b busy=%b, required tx=0 ready=0 busy=1",
                     name, cur_tx, cur_ready, cur_busy);
        end
        if (!hold_valid) set_valid(sel5, 1'b0);

        ticks = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < CYC_LIMIT; cyc++) begin
            @(negedge clk);
            if (ticks == total) begin
                checks++;
                if (cur_done !== 1'b1 || cur_ready !== 1'b1 || cur_tx !== 1'b1) begin
                    errors++;
                    $display("FAIL %s end: done=%b ready=%b tx=%b, required done=1 ready=1 tx=1",
                             name, cur_done, cur_ready, cur_tx);
                end
                finished = 1'b1;
                break;
            end
            checks++;
            if (cur_done !== 1'b0 || cur_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s inframe tick %0d: done=%b busy=%b, required done=0 busy=1",
                         name, ticks, cur_done, cur_busy);
            end
            if (baud) begin
                checks++;
                if (cur_tx !== exp_q[ticks / st]) begin
                    errors++;
                    $display("FAIL %s bit %0d tick %0d: tx=%b, required %b",
                             name, ticks / st, ticks, cur_tx, exp_q[ticks / st]);
                end
                ticks++;
            end
            if (noise) begin
                if ($urandom_range(0, 3) == 0) begin
                    if (sel5) begin data5 = 5'($urandom); par5 = 2'($urandom); stop5 = 1'($urandom); end
                    else      begin data8 = 8'($urandom); par8 = 2'($urandom); stop8 = 1'($urandom); end
                end
                if (!hold_valid) set_valid(sel5, 1'($urandom));
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: ticks seen %0d, required %0d then done", name, ticks, total);
        end
        if (!hold_valid) set_valid(sel5, 1'b0);
    endtask

    task automatic test_reset();
        valid8 = 1'b1;
        valid5 = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL reset8: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0", tx8, ready8, busy8, done8);
        end
        checks++;
        if (tx5 !== 1'b1 || ready5 !== 1'b1 || busy5 !== 1'b0 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL reset5: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0", tx5, ready5, busy5, done5);
        end
        valid8 = 1'b0;
        valid5 = 1'b0;
        reset_n = 1'b1;
        cur_sel = 1'b0;
        idle_cycles(6, "post_reset8");
        cur_sel = 1'b1;
        idle_cycles(2, "post_reset5");
    endtask

    task automatic test_basic();
        run_frame(1'b0, 9'h055, 2'b00, 1'b0, 1'b0, 1'b0, "frame_55");
        idle_cycles(3, "after_55");
    endtask

    task automatic test_parity();
        run_frame(1'b0, 9'h0CC, 2'b01, 1'b0, 1'b0, 1'b0, "cc_even");
        idle_cycles(2, "after_cc_even");
        run_frame(1'b0, 9'h0CC, 2'b10, 1'b0, 1'b0, 1'b0, "cc_odd");
        idle_cycles(2, "after_cc_odd");
        run_frame(1'b0, 9'h0B1, 2'b11, 1'b1, 1'b0, 1'b0, "reserved_mode");
        idle_cycles(2, "after_reserved");
    endtask

    task automatic test_word5();
        run_frame(1'b1, 9'h013, 2'b00, 1'b1, 1'b0, 1'b0, "w5_13_stop2");
        idle_cycles(2, "after_w5");
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, 9'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b1, "w5_random");
            idle_cycles($urandom_range(1, 4), "after_w5_random");
        end
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 9'h0A5, 2'b00, 1'b0, 1'b1, 1'b0, "b2b_first");
        run_frame(1'b0, 9'h03C, 2'b01, 1'b1, 1'b0, 1'b0, "b2b_second");
        idle_cycles(3, "after_b2b");
        run_frame(1'b0, 9'h0E7, 2'b10, 1'b0, 1'b0, 1'b1, "midframe_pulses");
        idle_cycles(3, "after_pulses");
    endtask

    task automatic test_mid_reset();
        int ticks;
        bit reached;
        cur_sel = 1'b0;
        data8 = 8'h96; par8 = 2'b01; stop8 = 1'b0; valid8 = 1'b1;
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        ticks = 0;
        reached = 1'b0;
        for (int cyc = 0; cyc < CYC_LIMIT; cyc++) begin
            @(negedge clk);
            if (baud) ticks++;
            if (ticks >= 3 * ST8 + 5) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached || busy8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset setup: reached=%b busy=%b, required 1 1", reached, busy8);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset abort: tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx8, ready8, busy8, done8);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle_cycles(5, "after_mid_reset");
        run_frame(1'b0, 9'h00F, 2'b00, 1'b0, 1'b0, 1'b0, "frame_0F");
        idle_cycles(2, "after_0F");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_frame(1'b0, 9'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b1, "random8");
            idle_cycles($urandom_range(1, 5), "after_random8");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_word5();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
